branch_resolver: RTL and testbench
==================================

# branch_resolver

Resolves control-transfer instructions at the resolution stage against the prediction made at fetch by the BTB, and drives the BTB update port and the fetch redirect/flush. It is the write/correction end of the BTB loop: IF reads the BTB and predicts, `branch_resolver` checks the prediction `BRANCH_STALL_CYCLES` cycles later and writes the BTB back. It sits between IF (prediction capture) and EX (outcome), and its outputs feed the PC mux, the BTB write port and the younger pipeline registers.

## Interface
- `DATA_WIDTH`, `global_params::DATA_WIDTH` (32): PC/target width.
- `STALL_CYCLES`, `global_params::BRANCH_STALL_CYCLES` (2, must be ≥1): fetch-to-resolve distance in un-stalled cycles.
- `clk`  in  1  clock; all state on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  pipeline stall; holds all tracking state.
- `if_valid`  in  1  IF fetched an instruction this cycle.
- `if_pc`  in  DATA_WIDTH  fetch PC.
- `if_hit`  in  1  BTB hit for `if_pc`.
- `if_trgt`  in  DATA_WIDTH  BTB predicted target.
- `ex_valid`  in  1  resolution slot holds a valid instruction.
- `ex_is_branch`  in  1  instruction is a control transfer.
- `ex_taken`  in  1  actual outcome taken.
- `ex_trgt`  in  DATA_WIDTH  actual taken target.
- `redirect`  out  1  one-cycle pulse: load `redirect_pc` into PC.
- `redirect_pc`  out  DATA_WIDTH  corrected next PC.
- `flush`  out  1  squash younger stages.
- `btb_we`  out  1  BTB write enable (one-cycle pulse).
- `btb_pc`  out  DATA_WIDTH  BTB write tag/index PC.
- `btb_trgt`  out  DATA_WIDTH  BTB write data.
- `branch_cnt`  out  32  resolved control transfers.
- `mispredict_cnt`  out  32  mispredictions.

## Operation
- Prediction queue: `STALL_CYCLES` records `{valid, pc, hit, trgt}`. On each edge with `!stall`: slot0 ← `{if_valid, if_pc, if_hit, if_trgt}`, slot k ← slot k−1. Slot `STALL_CYCLES-1` is the record for the instruction at resolution.
- Predicted next PC = `hit ? trgt : pc+4`. Actual next PC = `(ex_is_branch && ex_taken) ? ex_trgt : pc+4`. All adds are modulo 2^DATA_WIDTH.
- Resolution happens in a cycle with `!stall`, state IDLE, `ex_valid`, and a valid tail record. A record that is not valid means no resolution, even if `ex_valid` is high.
- Mispredict = resolution && actual ≠ predicted. On a mispredict:
  - `redirect` pulses with `redirect_pc` = actual next PC.
  - All queue valid bits are cleared on that edge; the new slot0 is still captured.
  - `mispredict_cnt` increments.
  - FSM enters SQUASH.
- BTB write = resolution && `ex_is_branch && ex_taken` && (`!hit` || `trgt ≠ ex_trgt`), with `btb_pc` = record pc and `btb_trgt` = `ex_trgt`. Not-taken with hit redirects to pc+4 and does not write the BTB.
- `branch_cnt` increments on every resolution with `ex_is_branch`. Both counters wrap at 2^32.
- FSM:
  - IDLE → SQUASH on a mispredict, with the counter loaded to `STALL_CYCLES`.
  - In SQUASH: `flush`=1. The counter decrements on each `!stall` cycle. → IDLE when the counter reaches 1 and `!stall`.
  - Resolutions are ignored in SQUASH; those instructions are wrong-path.
- `rst` (including mid-SQUASH): queue invalid, FSM IDLE, counters 0, all outputs 0.

## Timing
- Fetch in cycle f resolves in cycle f+`STALL_CYCLES`, plus one cycle for each intervening stall cycle.
- Resolution in cycle t → `redirect`, `btb_we` and their data appear in cycle t+1 (registered), for exactly one cycle. Only `flush` is held longer.
- `flush` is high in cycles t+1 … t+`STALL_CYCLES` (longer if stalled).
- `stall` in cycle t+1 does not extend the `redirect` or `btb_we` pulses.
- The first correct-path fetch is in cycle t+1, so it resolves in t+1+`STALL_CYCLES`, after SQUASH has ended.
- With `stall`=1: no resolution, no counter or queue change, outputs `redirect`/`btb_we` return to 0.

## Structure
- `global_params`: `BRANCH_STALL_CYCLES` (existing), `DATA_WIDTH`. Add the typedef `pred_rec_t` (valid, pc, hit, trgt) and the FSM enum `resolve_state_t {IDLE, SQUASH}`.
- Sub-module `branch_pred_queue`: a parameterized stall-aware shift register of `pred_rec_t`, with a clear-valid input. All compare, FSM, counter and output logic stays in `branch_resolver`.

## Test plan
Bench configuration: `STALL_CYCLES`=2, `DATA_WIDTH`=32.
- Reset → all outputs 0. Then `ex_valid`=1 with no prior fetch → no `redirect` and `branch_cnt`=0.
- Fetch 0x100, miss; resolve two cycles later, branch not taken → `redirect`=0, `btb_we`=0, `branch_cnt`=1, `mispredict_cnt`=0.
- Fetch 0x100, miss; resolve taken with `ex_trgt`=0x200 → next cycle:
  - `redirect`=1 with `redirect_pc`=0x200;
  - `btb_we`=1 with `btb_pc`=0x100 and `btb_trgt`=0x200;
  - `flush` high 2 cycles;
  - `mispredict_cnt`=1.
- Fetch 0x100, hit with `trgt`=0x180; resolve taken to 0x200 → redirect to 0x200 and BTB write 0x100→0x200. Same case with `trgt`=0x200 → no redirect, no write.
- Fetch 0x100, hit with `trgt`=0x200; resolve not taken → `redirect_pc`=0x104, `btb_we`=0.
- Stall and squash, in three steps:
  - Fetch 0x100, stall 3 cycles, then resolve → resolution occurs 5 cycles after the fetch with correct alignment.
  - A mispredict followed by a second `ex_valid` mispredicting branch during SQUASH → only one `redirect`.
  - `rst` mid-SQUASH → `flush` drops the next cycle.

Source files
------------

// File: rtl/global_params.sv
// Shared widths, the prediction record carried from fetch to resolution,
// and the resolver FSM encoding.
package global_params;

    localparam int DATA_WIDTH          = 32;
    localparam int BRANCH_STALL_CYCLES = 2;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic                  hit;
        logic [DATA_WIDTH-1:0] trgt;
    } pred_rec_t;

    typedef enum logic {
        IDLE,
        SQUASH
    } resolve_state_t;

endpackage

// File: rtl/branch_pred_queue.sv
// Stall-aware shift register that carries BTB predictions from fetch to the
// resolution stage; clr_valid kills every in-flight record but still captures din.
module branch_pred_queue
    import global_params::*;
#(
    parameter int DEPTH = BRANCH_STALL_CYCLES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      clr_valid,
    input  pred_rec_t din,
    output pred_rec_t tail
);

    pred_rec_t slots [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!stall) begin
            slots[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
                if (clr_valid) begin
                    slots[i].valid <= 1'b0;
                end
            end
        end
    end

    assign tail = slots[DEPTH-1];

endmodule

// File: rtl/branch_resolver.sv
// Checks the fetch-time BTB prediction against the resolved outcome, drives
// the PC redirect / flush, and writes corrected targets back into the BTB.
//
// state  | meaning
// IDLE   | resolving normally
// SQUASH | wrong-path instructions draining; flush held, resolutions ignored
module branch_resolver
    import global_params::*;
#(
    parameter int DATA_WIDTH   = global_params::DATA_WIDTH,
    parameter int STALL_CYCLES = BRANCH_STALL_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] if_pc,
    input  logic                  if_hit,
    input  logic [DATA_WIDTH-1:0] if_trgt,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic                  ex_taken,
    input  logic [DATA_WIDTH-1:0] ex_trgt,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic                  btb_we,
    output logic [DATA_WIDTH-1:0] btb_pc,
    output logic [DATA_WIDTH-1:0] btb_trgt,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispredict_cnt
);

    localparam int CW = $clog2(STALL_CYCLES + 1);

    pred_rec_t             in_rec;
    pred_rec_t             tail;
    resolve_state_t        state, state_nx;
    logic [CW-1:0]         sq_cnt, sq_cnt_nx;
    logic                  resolve, is_taken, mispredict, btb_write;
    logic [DATA_WIDTH-1:0] seq_pc, pred_pc, actual_pc;

    assign in_rec = '{valid: if_valid, pc: if_pc, hit: if_hit, trgt: if_trgt};

    branch_pred_queue #(
        .DEPTH (STALL_CYCLES)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .clr_valid (mispredict),
        .din       (in_rec),
        .tail      (tail)
    );

    assign seq_pc     = tail.pc + DATA_WIDTH'(4);
    assign is_taken   = ex_is_branch && ex_taken;
    assign pred_pc    = tail.hit ? tail.trgt : seq_pc;
    assign actual_pc  = is_taken ? ex_trgt : seq_pc;
    assign resolve    = !stall && (state == IDLE) && ex_valid && tail.valid;
    assign mispredict = resolve && (actual_pc != pred_pc);
    assign btb_write  = resolve && is_taken && (!tail.hit || (tail.trgt != ex_trgt));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sq_cnt <= '0;
        end else begin
            state  <= state_nx;
            sq_cnt <= sq_cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sq_cnt_nx = sq_cnt;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_nx  = SQUASH;
                    sq_cnt_nx = CW'(STALL_CYCLES);
                end
            end
            SQUASH: begin
                if (!stall) begin
                    if (sq_cnt == CW'(1)) begin
                        state_nx = IDLE;
                    end
                    sq_cnt_nx = sq_cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        flush = (state == SQUASH);
    end

    // Redirect and BTB write are single-cycle pulses; data reads zero between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            btb_we         <= 1'b0;
            btb_pc         <= '0;
            btb_trgt       <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect    <= mispredict;
            redirect_pc <= mispredict ? actual_pc : '0;
            btb_we      <= btb_write;
            btb_pc      <= btb_write ? tail.pc : '0;
            btb_trgt    <= btb_write ? ex_trgt : '0;
            if (resolve && ex_is_branch) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed literal cases plus a random run checked
// every cycle against an epoch-tagged reference model of the fetch/resolve loop.
module tb_branch_resolver;

    localparam int S  = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          if_valid = 1'b0;
    logic [DW-1:0] if_pc = '0;
    logic          if_hit = 1'b0;
    logic [DW-1:0] if_trgt = '0;
    logic          ex_valid = 1'b0;
    logic          ex_is_branch = 1'b0;
    logic          ex_taken = 1'b0;
    logic [DW-1:0] ex_trgt = '0;

    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          flush;
    logic          btb_we;
    logic [DW-1:0] btb_pc;
    logic [DW-1:0] btb_trgt;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispredict_cnt;

    branch_resolver #(
        .DATA_WIDTH   (DW),
        .STALL_CYCLES (S)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_hit         (if_hit),
        .if_trgt        (if_trgt),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_trgt        (ex_trgt),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .btb_we         (btb_we),
        .btb_pc         (btb_pc),
        .btb_trgt       (btb_trgt),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: each in-flight fetch carries the epoch it was fetched in;
    // a mispredict opens a new epoch and a squash window of S un-stalled cycles.
    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        hit;
        bit [31:0] trgt;
        int        ep;
    } mrec_t;

    mrec_t     hist[$];
    int        epoch = 0;
    int        busy = 0;
    bit [31:0] m_branch = 0, m_mis = 0;
    bit        m_redirect = 0, m_btb_we = 0, m_flush = 0;
    bit [31:0] m_redirect_pc = 0, m_btb_pc = 0, m_btb_trgt = 0;
    bit        model_ok = 0;

    always @(posedge clk) begin : model
        mrec_t     tl;
        mrec_t     nr;
        bit        res;
        bit [31:0] pred, act;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < S; i++) hist.push_back('{0, 0, 0, 0, -1});
            epoch = 0; busy = 0; m_branch = 0; m_mis = 0;
            m_redirect = 0; m_btb_we = 0; m_flush = 0;
            m_redirect_pc = 0; m_btb_pc = 0; m_btb_trgt = 0;
            model_ok = 1;
        end else begin
            m_redirect = 0; m_btb_we = 0;
            m_redirect_pc = 0; m_btb_pc = 0; m_btb_trgt = 0;
            if (!stall) begin
                tl   = hist[S-1];
                res  = (busy == 0) && ex_valid && tl.v && (tl.ep == epoch);
                pred = tl.hit ? tl.trgt : tl.pc + 32'd4;
                act  = (ex_is_branch && ex_taken) ? ex_trgt : tl.pc + 32'd4;
                if (busy > 0) busy--;
                if (res) begin
                    if (ex_is_branch) m_branch++;
                    if (act != pred) begin
                        m_mis++;
                        m_redirect = 1; m_redirect_pc = act;
                        busy = S; epoch++;
                    end
                    if (ex_is_branch && ex_taken && (!tl.hit || tl.trgt != ex_trgt)) begin
                        m_btb_we = 1; m_btb_pc = tl.pc; m_btb_trgt = ex_trgt;
                    end
                end
                nr = '{if_valid, if_pc, if_hit, if_trgt, epoch};
                hist.push_front(nr);
                void'(hist.pop_back());
            end
            m_flush = (busy > 0);
        end
    end

    always @(posedge clk) begin : compare
        #2;
        if (model_ok) begin
            n_total++;
            if (redirect === m_redirect && redirect_pc === m_redirect_pc && flush === m_flush &&
                btb_we === m_btb_we && btb_pc === m_btb_pc && btb_trgt === m_btb_trgt &&
                branch_cnt === m_branch && mispredict_cnt === m_mis) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t got redir=%b/%h flush=%b we=%b/%h/%h bc=%0d mc=%0d expected redir=%b/%h flush=%b we=%b/%h/%h bc=%0d mc=%0d",
                         $time, redirect, redirect_pc, flush, btb_we, btb_pc, btb_trgt, branch_cnt, mispredict_cnt,
                         m_redirect, m_redirect_pc, m_flush, m_btb_we, m_btb_pc, m_btb_trgt, m_branch, m_mis);
            end
        end
    end

    task automatic step(input bit st, input bit iv, input bit [31:0] ipc, input bit ih, input bit [31:0] it,
                        input bit ev, input bit br, input bit tk, input bit [31:0] et);
        stall = st; if_valid = iv; if_pc = ipc; if_hit = ih; if_trgt = it;
        ex_valid = ev; ex_is_branch = br; ex_taken = tk; ex_trgt = et;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_btb_we", {31'd0, btb_we}, 32'd0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispredict_cnt", mispredict_cnt, 32'd0);
        rst = 1'b0;

        // resolution slot valid with nothing fetched
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h300);
        chk("nofetch_redirect", {31'd0, redirect}, 32'd0);
        chk("nofetch_branch_cnt", branch_cnt, 32'd0);

        // miss, not taken
        step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("nt_redirect", {31'd0, redirect}, 32'd0);
        chk("nt_btb_we", {31'd0, btb_we}, 32'd0);
        chk("nt_branch_cnt", branch_cnt, 32'd1);
        chk("nt_mispredict_cnt", mispredict_cnt, 32'd0);

        // miss, taken to 0x200
        step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
        chk("miss_tk_redirect", {31'd0, redirect}, 32'd1);
        chk("miss_tk_redirect_pc", redirect_pc, 32'h200);
        chk("miss_tk_btb_we", {31'd0, btb_we}, 32'd1);
        chk("miss_tk_btb_pc", btb_pc, 32'h100);
        chk("miss_tk_btb_trgt", btb_trgt, 32'h200);
        chk("miss_tk_flush1", {31'd0, flush}, 32'd1);
        chk("miss_tk_mispredict_cnt", mispredict_cnt, 32'd1);
        idle();
        chk("miss_tk_flush2", {31'd0, flush}, 32'd1);
        chk("miss_tk_redirect_pulse", {31'd0, redirect}, 32'd0);
        chk("miss_tk_btb_we_pulse", {31'd0, btb_we}, 32'd0);
        idle();
        chk("miss_tk_flush_end", {31'd0, flush}, 32'd0);

        // hit with stale target
        step(0, 1, 32'h100, 1, 32'h180, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
        chk("stale_redirect_pc", redirect_pc, 32'h200);
        chk("stale_btb_we", {31'd0, btb_we}, 32'd1);
        chk("stale_btb_pc", btb_pc, 32'h100);
        chk("stale_btb_trgt", btb_trgt, 32'h200);
        idle(); idle();

        // hit with correct target
        step(0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
        chk("good_redirect", {31'd0, redirect}, 32'd0);
        chk("good_btb_we", {31'd0, btb_we}, 32'd0);
        chk("good_branch_cnt", branch_cnt, 32'd4);

        // hit but not taken
        step(0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("hit_nt_redirect", {31'd0, redirect}, 32'd1);
        chk("hit_nt_redirect_pc", redirect_pc, 32'h104);
        chk("hit_nt_btb_we", {31'd0, btb_we}, 32'd0);
        chk("hit_nt_mispredict_cnt", mispredict_cnt, 32'd3);
        idle(); idle();

        // fetch, three stall cycles, resolves five cycles after fetch
        step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1, 1, 32'h999);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("stall_early_branch_cnt", branch_cnt, 32'd5);
        chk("stall_early_redirect", {31'd0, redirect}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h240);
        chk("stall_redirect_pc", redirect_pc, 32'h240);
        chk("stall_branch_cnt", branch_cnt, 32'd6);
        idle(); idle();

        // second mispredicting branch during SQUASH is ignored
        step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
        chk("dbl_redirect1", {31'd0, redirect}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h500);
        chk("dbl_redirect2", {31'd0, redirect}, 32'd0);
        chk("dbl_mispredict_cnt", mispredict_cnt, 32'd5);
        chk("dbl_branch_cnt", branch_cnt, 32'd7);
        idle();
        chk("dbl_flush_end", {31'd0, flush}, 32'd0);

        // reset while squashing
        step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0); idle();
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h200);
        chk("rsq_flush", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        idle();
        chk("rsq_flush_after", {31'd0, flush}, 32'd0);
        chk("rsq_mispredict_cnt", mispredict_cnt, 32'd0);
        chk("rsq_branch_cnt", branch_cnt, 32'd0);
        rst = 1'b0;

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit [31:0] t_pc, t_it, t_et;
            rst  = ($urandom_range(0, 499) == 0);
            t_pc = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            t_it = ($urandom_range(0, 3) == 0) ? t_pc + 32'd4 : 32'h200 + 32'($urandom_range(0, 3)) * 4;
            t_et = 32'h200 + 32'($urandom_range(0, 3)) * 4;
            step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 70, t_pc, $urandom_range(0, 1) == 1, t_it,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1, t_et);
        end
        rst = 1'b0;
        idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
